// File: rtl/student_ss_analog_status_sampler.sv
// Samples the analog student area's four status words into the SoC clock domain.
// Snapshots are taken on a programmable periodic tick or on a software trigger.
// Words that changed between snapshots set sticky flags, which drive a maskable
// level interrupt. All state is visible through a zero-wait APB slave.
//
// Ports:
//   clk_in, reset_int            system clock, synchronous active-low reset
//   status_0..status_3           asynchronous quasi-static analog status words
//   PSEL/PENABLE/PWRITE/PADDR/   APB slave request
//   PWDATA
//   PRDATA/PREADY/PSLVERR        APB slave response (combinational, zero wait)
//   irq                          registered level interrupt
module student_ss_analog_status_sampler #(
    parameter int unsigned APB_AW      = 10,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset_int,
    input  logic [31:0]       status_0,
    input  logic [31:0]       status_1,
    input  logic [31:0]       status_2,
    input  logic [31:0]       status_3,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irq
);

    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CNT_W     = 16;

    logic [WORD_W-1:0] status [NUM_WORDS];
    logic [WORD_W-1:0] sync_q [NUM_WORDS][SYNC_STAGES];
    logic [WORD_W-1:0] snap_q [NUM_WORDS];

    logic              en_q;
    logic [3:0]        irq_en_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  tick_cnt_q;
    logic [3:0]        chg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              irq_q;

    logic [2:0]        idx_c;
    logic              access_c;
    logic              upper_nz_c;
    logic              err_c;
    logic              wr_ok_c;
    logic              ctrl_wr_c;
    logic              div_wr_c;
    logic              chg_wr_c;
    logic              tick_c;
    logic              sample_c;
    logic [3:0]        chg_set_c;
    logic [3:0]        chg_clr_c;
    logic              unused_bits;

    assign status[0] = status_0;
    assign status[1] = status_1;
    assign status[2] = status_2;
    assign status[3] = status_3;

    // Address low bits are byte lanes and never decoded.
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    // APB decode: offsets 0x00..0x1C are all mapped; 0x0C and above are read-only.
    assign idx_c      = PADDR[4:2];
    assign access_c   = PSEL & PENABLE;
    assign upper_nz_c = (PADDR >> 5) != '0;
    assign err_c      = access_c & (upper_nz_c | (PWRITE & (idx_c >= 3'd3)));
    assign wr_ok_c    = access_c & PWRITE & ~err_c;
    assign ctrl_wr_c  = wr_ok_c & (idx_c == 3'd0);
    assign div_wr_c   = wr_ok_c & (idx_c == 3'd1);
    assign chg_wr_c   = wr_ok_c & (idx_c == 3'd2);

    // Tick fires on the last count of each DIV+1 period.
    assign tick_c    = en_q & (tick_cnt_q == '0);
    assign sample_c  = tick_c | (ctrl_wr_c & PWDATA[1]);
    assign chg_clr_c = chg_wr_c ? PWDATA[3:0] : 4'h0;

    // A word is flagged when the synchronised value differs from its previous snapshot.
    always_comb begin
        chg_set_c = '0;
        for (int unsigned n = 0; n < NUM_WORDS; n++) begin
            chg_set_c[n] = sample_c & (sync_q[n][SYNC_STAGES-1] != snap_q[n]);
        end
    end

    // Input synchroniser chains.
    always_ff @(posedge clk_in) begin
        if (!reset_int) begin
            for (int unsigned n = 0; n < NUM_WORDS; n++) begin
                for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                    sync_q[n][s] <= '0;
                end
            end
        end else begin
            for (int unsigned n = 0; n < NUM_WORDS; n++) begin
                sync_q[n][0] <= status[n];
                for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[n][s] <= sync_q[n][s-1];
                end
            end
        end
    end

    // Control, timer, snapshot and interrupt state.
    always_ff @(posedge clk_in) begin
        if (!reset_int) begin
            en_q       <= 1'b0;
            irq_en_q   <= '0;
            div_q      <= DIV_W'(16'h00FF);
            tick_cnt_q <= '0;
            chg_q      <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            for (int unsigned n = 0; n < NUM_WORDS; n++) begin
                snap_q[n] <= '0;
            end
        end else begin
            if (ctrl_wr_c) begin
                en_q     <= PWDATA[0];
                irq_en_q <= PWDATA[7:4];
            end
            if (div_wr_c) begin
                div_q <= PWDATA[DIV_W-1:0];
            end

            // A DIV write restarts the period with the new value; disabled holds at DIV.
            if (div_wr_c) begin
                tick_cnt_q <= PWDATA[DIV_W-1:0];
            end else if (!en_q || tick_c) begin
                tick_cnt_q <= div_q;
            end else begin
                tick_cnt_q <= tick_cnt_q - DIV_W'(1);
            end

            if (sample_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
                for (int unsigned n = 0; n < NUM_WORDS; n++) begin
                    snap_q[n] <= sync_q[n][SYNC_STAGES-1];
                end
            end

            // Set beats clear on a same-cycle collision.
            chg_q <= (chg_q & ~chg_clr_c) | chg_set_c;
            irq_q <= |(chg_q & irq_en_q);
        end
    end

    // Read mux; erroring or idle cycles return zero.
    always_comb begin
        PRDATA = '0;
        if (access_c && !err_c) begin
            case (idx_c)
                3'd0:    PRDATA = {24'h0, irq_en_q, 3'b000, en_q};
                3'd1:    PRDATA = 32'(div_q);
                3'd2:    PRDATA = {28'h0, chg_q};
                3'd3:    PRDATA = 32'(cnt_q);
                default: PRDATA = snap_q[idx_c[1:0]];
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = err_c;
    assign irq     = irq_q;

endmodule

// File: tb/tb_student_ss_analog_status_sampler.sv
// Self-checking bench for student_ss_analog_status_sampler: directed scenarios plus
// randomized APB/status traffic checked against a cycle-level reference model.
module tb_student_ss_analog_status_sampler;

    localparam int unsigned APB_AW      = 10;
    localparam int unsigned DIV_W       = 16;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk_in    = 1'b0;
    logic              reset_int = 1'b0;
    logic [31:0]       status_0  = '0;
    logic [31:0]       status_1  = '0;
    logic [31:0]       status_2  = '0;
    logic [31:0]       status_3  = '0;
    logic              PSEL      = 1'b0;
    logic              PENABLE   = 1'b0;
    logic              PWRITE    = 1'b0;
    logic [APB_AW-1:0] PADDR     = '0;
    logic [31:0]       PWDATA    = '0;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0]  m_snap [4];
    logic [3:0]   m_chg;
    logic [3:0]   m_irq_en;
    logic         m_en;
    logic         m_irq;
    logic [15:0]  m_cnt;
    logic [15:0]  m_div;
    int           m_elapsed;
    logic [127:0] hist [$];

    student_ss_analog_status_sampler #(
        .APB_AW(APB_AW), .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_in(clk_in), .reset_int(reset_int),
        .status_0(status_0), .status_1(status_1), .status_2(status_2), .status_3(status_3),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .irq(irq)
    );

    always #5 clk_in = ~clk_in;

    // One clock edge of the behavioural model: inputs seen at the edge, updates after it.
    task automatic model_step();
        logic [127:0] cap;
        logic [2:0]   ix;
        logic         ok, wr, trig, tick, smp;
        logic [3:0]   set, clr;
        logic [31:0]  w;
        if (!reset_int) begin
            m_en = 1'b0; m_irq_en = '0; m_div = 16'h00FF; m_chg = '0;
            m_cnt = '0; m_irq = 1'b0; m_elapsed = 0;
            for (int n = 0; n < 4; n++) m_snap[n] = '0;
            hist.delete();
            for (int s = 0; s < SYNC_STAGES; s++) hist.push_back('0);
        end else begin
            // Captured value is the input as it stood SYNC_STAGES edges earlier.
            cap = hist.pop_front();
            hist.push_back({status_3, status_2, status_1, status_0});
            ix   = PADDR[4:2];
            ok   = PSEL && PENABLE && ((PADDR >> 5) == '0);
            wr   = ok && PWRITE && (ix < 3'd3);
            trig = wr && (ix == 3'd0) && PWDATA[1];
            tick = m_en && (((m_elapsed + 1) % (int'(m_div) + 1)) == 0);
            smp  = tick || trig;
            m_irq = |(m_chg & m_irq_en);
            set = '0;
            for (int n = 0; n < 4; n++) begin
                w = cap[32*n +: 32];
                if (smp && (w != m_snap[n])) set[n] = 1'b1;
                if (smp) m_snap[n] = w;
            end
            clr = (wr && ix == 3'd2) ? PWDATA[3:0] : 4'h0;
            m_chg = (m_chg & ~clr) | set;
            if (smp) m_cnt = m_cnt + 16'd1;
            m_elapsed = m_en ? m_elapsed + 1 : 0;
            if (wr && ix == 3'd0) begin
                if (!m_en) m_elapsed = 0;
                m_en     = PWDATA[0];
                m_irq_en = PWDATA[7:4];
            end
            if (wr && ix == 3'd1) begin
                m_div     = PWDATA[15:0];
                m_elapsed = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    function automatic logic [31:0] exp_rdata(input logic [APB_AW-1:0] a);
        logic [2:0] ix;
        ix = a[4:2];
        if ((a >> 5) != '0) return 32'h0;
        case (ix)
            3'd0:    return {24'h0, m_irq_en, 3'b000, m_en};
            3'd1:    return {16'h0, m_div};
            3'd2:    return {28'h0, m_chg};
            3'd3:    return {16'h0, m_cnt};
            default: return m_snap[ix[1:0]];
        endcase
    endfunction

    function automatic logic exp_err(input logic [APB_AW-1:0] a, input logic w);
        return ((a >> 5) != '0) || (w && (a[4:2] >= 3'd3));
    endfunction

    task automatic apb_write(input logic [APB_AW-1:0] a, input logic [31:0] d, output logic e);
        @(negedge clk_in);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge clk_in);
        PENABLE = 1'b1;
        #1 e = PSLVERR;
        @(negedge clk_in);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Returns DUT response plus the model's view at the same instant of the access phase.
    task automatic apb_read(input logic [APB_AW-1:0] a, output logic [31:0] d, output logic e,
                            output logic [31:0] xd, output logic xe);
        @(negedge clk_in);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge clk_in);
        PENABLE = 1'b1;
        #1 d = PRDATA; e = PSLVERR; xd = exp_rdata(a); xe = exp_err(a, 1'b0);
        @(negedge clk_in);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, xd, want;
        logic        e, xe;
        // APB write to DIV while reset is held must leave no trace.
        reset_int = 1'b0;
        @(negedge clk_in);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 10'h004; PWDATA = 32'h1234;
        @(negedge clk_in);
        PENABLE = 1'b1;
        @(negedge clk_in);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge clk_in);
        reset_int = 1'b1;
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        n_tests++;
        if (PREADY !== 1'b1) begin n_fail++; $display("FAIL reset_pready got %b want 1", PREADY); end
        for (int i = 0; i < 8; i++) begin
            apb_read(10'(i * 4), d, e, xd, xe);
            want = (i == 1) ? 32'h0000_00FF : 32'h0;
            n_tests++;
            if (d !== want || e !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_reg%0d got %h/%b want %h/0", i, d, e, want);
            end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d, xd;
        logic        e, xe;
        status_2 = 32'hA5A5_0001;
        apb_write(10'h004, 32'd9, e);
        apb_write(10'h000, 32'h1, e);
        repeat (30) @(negedge clk_in);
        apb_read(10'h00C, d, e, xd, xe);
        n_tests++;
        if (d !== 32'd3) begin n_fail++; $display("FAIL periodic_cnt got %h want 3", d); end
        apb_read(10'h018, d, e, xd, xe);
        n_tests++;
        if (d !== 32'hA5A5_0001) begin n_fail++; $display("FAIL periodic_snap2 got %h want a5a50001", d); end
        apb_read(10'h008, d, e, xd, xe);
        n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL periodic_chg got %h want 4", d); end
        apb_write(10'h000, 32'h0, e);
    endtask

    task automatic test_change_irq();
        logic [31:0] d, xd;
        logic        e, xe;
        apb_write(10'h000, 32'h10, e);
        status_0 = 32'h0000_1234;
        repeat (3) @(negedge clk_in);
        apb_write(10'h000, 32'h12, e);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency_early got %b want 0", irq); end
        @(negedge clk_in);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise got %b want 1", irq); end
        apb_read(10'h008, d, e, xd, xe);
        n_tests++;
        if (d[0] !== 1'b1 || d !== xd) begin n_fail++; $display("FAIL chg_after_change got %h want %h", d, xd); end
        apb_write(10'h008, 32'h1, e);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_clear_early got %b want 1", irq); end
        @(negedge clk_in);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
        apb_read(10'h008, d, e, xd, xe);
        n_tests++;
        if (d[0] !== 1'b0 || d !== xd) begin n_fail++; $display("FAIL chg_w1c got %h want %h", d, xd); end
    endtask

    task automatic test_collision();
        logic [31:0] d, xd;
        logic        e, xe;
        apb_write(10'h004, 32'h0, e);
        apb_write(10'h000, 32'h1, e);
        // The change reaches the capture point exactly on the W1C access edge.
        status_1 = 32'hDEAD_BEEF;
        apb_write(10'h008, 32'h2, e);
        apb_write(10'h000, 32'h0, e);
        apb_read(10'h008, d, e, xd, xe);
        n_tests++;
        if (d[1] !== 1'b1 || d !== xd) begin n_fail++; $display("FAIL collision_chg got %h want %h", d, xd); end
    endtask

    task automatic test_trigger();
        logic [31:0] d, xd;
        logic [15:0] c0;
        logic        e, xe;
        c0 = m_cnt;
        apb_write(10'h000, 32'h2, e);
        apb_read(10'h00C, d, e, xd, xe);
        n_tests++;
        if (d !== 32'(c0 + 16'd1)) begin n_fail++; $display("FAIL trig_cnt got %h want %h", d, c0 + 16'd1); end
        apb_read(10'h000, d, e, xd, xe);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL trig_ctrl_read got %h want 0", d); end
        repeat (5) @(negedge clk_in);
        apb_read(10'h00C, d, e, xd, xe);
        n_tests++;
        if (d !== 32'(c0 + 16'd1)) begin n_fail++; $display("FAIL trig_once got %h want %h", d, c0 + 16'd1); end
        // Trig landing on the same edge as a periodic tick counts once.
        apb_write(10'h004, 32'd3, e);
        c0 = m_cnt;
        apb_write(10'h000, 32'h1, e);
        @(negedge clk_in);
        apb_write(10'h000, 32'h3, e);
        apb_read(10'h00C, d, e, xd, xe);
        n_tests++;
        if (d !== 32'(c0 + 16'd1) || d !== xd) begin
            n_fail++; $display("FAIL trig_tick_merge got %h want %h", d, c0 + 16'd1);
        end
        apb_write(10'h000, 32'h0, e);
    endtask

    task automatic test_errors();
        logic [31:0] d, xd;
        logic        e, xe;
        apb_read(10'h020, d, e, xd, xe);
        n_tests++;
        if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL err_read_0x20 got %h/%b want 0/1", d, e); end
        apb_write(10'h010, 32'hFFFF_FFFF, e);
        n_tests++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL err_write_snap0 got %b want 1", e); end
        apb_read(10'h010, d, e, xd, xe);
        n_tests++;
        if (d !== xd || e !== 1'b0) begin n_fail++; $display("FAIL snap0_unchanged got %h/%b want %h/0", d, e, xd); end
        apb_read(10'h044, d, e, xd, xe);
        n_tests++;
        if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL err_upper_read got %h/%b want 0/1", d, e); end
        apb_write(10'h024, 32'hF1, e);
        n_tests++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL err_upper_write got %b want 1", e); end
        apb_read(10'h000, d, e, xd, xe);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_after_bad_write got %h want 0", d); end
        apb_write(10'h00C, 32'h5, e);
        n_tests++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL err_write_cnt got %b want 1", e); end
    endtask

    task automatic test_wrap();
        logic [31:0] d, xd;
        logic [15:0] c0;
        logic        e, xe;
        apb_write(10'h004, 32'h0, e);
        c0 = m_cnt;
        apb_write(10'h000, 32'h1, e);
        // Enable edge through disable edge spans exactly 65536 sample edges.
        repeat (65533) @(negedge clk_in);
        apb_write(10'h000, 32'h0, e);
        apb_read(10'h00C, d, e, xd, xe);
        n_tests++;
        if (d !== 32'(c0) || d !== xd) begin n_fail++; $display("FAIL cnt_wrap got %h want %h", d, c0); end
    endtask

    task automatic test_random();
        logic [31:0]       d, xd, wd;
        logic              e, xe, w;
        logic [2:0]        ix;
        logic [4:0]        up;
        logic [APB_AW-1:0] a;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       status_0 = $urandom;
                    1:       status_1 = $urandom;
                    2:       status_2 = $urandom;
                    default: status_3 = $urandom;
                endcase
            end
            ix = 3'($urandom_range(0, 7));
            up = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            a  = {up, ix, 2'b00};
            w  = 1'($urandom_range(0, 1));
            if (w) begin
                wd = $urandom;
                if (ix == 3'd1) wd = wd & 32'hF;
                apb_write(a, wd, e);
                n_tests++;
                if (e !== exp_err(a, 1'b1)) begin
                    n_fail++; $display("FAIL rnd_wr_err addr=%h got %b want %b", a, e, exp_err(a, 1'b1));
                end
            end else begin
                apb_read(a, d, e, xd, xe);
                n_tests++;
                if (d !== xd || e !== xe) begin
                    n_fail++; $display("FAIL rnd_rd addr=%h got %h/%b want %h/%b", a, d, e, xd, xe);
                end
            end
            repeat ($urandom_range(0, 6)) @(negedge clk_in);
            n_tests++;
            if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq got %b want %b", irq, m_irq); end
        end
        for (int i = 0; i < 8; i++) begin
            apb_read(10'(i * 4), d, e, xd, xe);
            n_tests++;
            if (d !== xd || e !== 1'b0) begin
                n_fail++; $display("FAIL rnd_final_reg%0d got %h/%b want %h/0", i, d, e, xd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_change_irq();
        test_collision();
        test_trigger();
        test_errors();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
